uart_tx_feeder: RTL and testbench
=================================

Name: uart_tx_feeder

Overview:
Byte FIFO plus load sequencer sitting directly upstream of the uart transmitter. Software-side logic pushes bytes at will. The block buffers them and hands them one at a time to the uart via ld_tx_data/tx_data, pacing on the uart's tx_empty. Runs entirely in the txclk domain.

Parameters:
DEPTH, 8, FIFO entries; power of two, >= 2.
ADDR_W, 3, log2(DEPTH); pointer width.

Ports:
txclk  input  1  transmit clock; all state on rising edge.
reset  input  1  asynchronous, active-high reset.
wr_en  input  1  push strobe; one byte per cycle while high.
wr_data  input  8  byte to push.
drain_en  input  1  enable draining FIFO into uart.
full  output  1  count == DEPTH.
fifo_empty  output  1  count == 0.
count  output  ADDR_W+1  current occupancy, 0..DEPTH.
ovf  output  1  sticky overflow flag (see Optional Feature).
ovf_clr  input  1  clears ovf.
ld_tx_data  output  1  one-cycle load strobe to uart.
tx_data  output  8  byte presented to uart; held stable until next load.
tx_enable  output  1  registered copy of drain_en, to uart tx_enable.
tx_empty  input  1  uart transmitter idle/holding-register-empty.

Behaviour:
- Reset (async, any time): rd_ptr=wr_ptr=0, count=0, state=IDLE. Outputs ld_tx_data=0, tx_data=8'h00, tx_enable=0, ovf=0. full=0, fifo_empty=1. Memory contents are don't-care.
- Push: on an edge with wr_en=1 and (count<DEPTH or pop on the same edge), write mem[wr_ptr]=wr_data and increment wr_ptr mod DEPTH.
- Push while full with no same-edge pop: byte dropped, pointers and count unchanged.
- Pop happens only on the IDLE->LOAD transition: rd_ptr increments mod DEPTH.
- Count: push-only +1, pop-only -1, push+pop unchanged. Pointers wrap naturally at DEPTH.
- full and fifo_empty decode combinationally from the registered count.
- tx_enable <= drain_en every edge (1-cycle latency).
- FSM states:
  IDLE: if drain_en=1, count>0 and tx_empty=1, then tx_data<=mem[rd_ptr], ld_tx_data<=1, pop, ->LOAD. Otherwise stay.
  LOAD: ld_tx_data<=0, ->WAIT_BUSY. ld_tx_data is high exactly one cycle.
  WAIT_BUSY: tx_empty=0 (uart accepted) ->WAIT_DONE. Otherwise stay.
  WAIT_DONE: tx_empty=1 ->IDLE.
- Latency: a push at edge N into an empty FIFO with uart idle gives ld_tx_data=1 after edge N+1 (count seen at N+1). The uart samples it at edge N+2.
- Back-to-back: the next load cannot start before the previous byte completes (tx_empty returns high), then +1 cycle through IDLE.
- drain_en deasserted mid-byte: the current byte finishes (FSM still walks WAIT_BUSY/WAIT_DONE). No new load until drain_en=1.
- Reset release while uart is busy: FSM waits in IDLE until tx_empty=1.

Optional Feature:
UART_TX_FEEDER_OVF_EN.
- Defined: ovf<=1 on any dropped push (wr_en=1, full, no same-edge pop).
- ovf_clr=1 clears ovf. If clear and a new drop occur on the same edge, the set wins.
- Not defined: ovf tied to 0 and ovf_clr ignored. Drop behaviour is otherwise identical.

Test Plan:
1. Reset mid-stream (3 bytes queued, state WAIT_DONE) -> immediately count=0, fifo_empty=1, ld_tx_data=0, tx_data=8'h00, ovf=0.
2. drain_en=1, tx_empty=1, push 8'h07 at edge N -> ld_tx_data=1 for exactly one cycle after edge N+1, tx_data=8'h07, count returns to 0.
3. Push 8'hAA,8'h55,8'h0F back-to-back; model uart holding tx_empty low 10 cycles per byte -> three single-cycle loads in order AA,55,0F, each only after tx_empty rises again.
4. drain_en=0, push DEPTH+2 bytes (0x01..0x0A) -> full=1, count=8, bytes 0x09/0x0A dropped. With UART_TX_FEEDER_OVF_EN, ovf=1; ovf_clr clears it. Without the macro, ovf stays 0.
5. Full FIFO, drain_en=1, push coincident with the pop edge -> byte accepted, count stays 8, no overflow. Draining shows pointer wrap with correct byte order.
6. Deassert drain_en during WAIT_BUSY -> current byte completes, FSM parks in IDLE with count unchanged. Reassert -> the next load resumes after a 1-cycle delay.

Source files
------------

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO plus load sequencer feeding a uart transmitter.
// Bytes are buffered and handed over one at a time through a single-cycle
// ld_tx_data strobe. Pacing follows the uart's tx_empty. Everything runs on txclk.
// Optional feature: define UART_TX_FEEDER_OVF_EN to enable the sticky overflow
// flag (ovf / ovf_clr). Without the macro, ovf is tied low.
module uart_tx_feeder #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              txclk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              drain_en,
  output logic              full,
  output logic              fifo_empty,
  output logic [ADDR_W:0]   count,
  output logic              ovf,
  input  logic              ovf_clr,
  output logic              ld_tx_data,
  output logic [7:0]        tx_data,
  output logic              tx_enable,
  input  logic              tx_empty
);

  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              pop;
  logic              push;

  // Status flags come straight from the registered occupancy.
  assign full       = (count == DEPTH_C);
  assign fifo_empty = (count == '0);

  // A pop is the IDLE->LOAD step. A push into a full FIFO is still accepted when
  // a pop on the same edge frees a slot.
  assign pop  = (state == IDLE) && drain_en && !fifo_empty && tx_empty;
  assign push = wr_en && (!full || pop);

  // Storage array. It has no reset, so contents after reset are don't-care.
  always_ff @(posedge txclk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers and occupancy. The pointers wrap naturally at DEPTH.
  always_ff @(posedge txclk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // uart-facing registers. The load strobe is high only for the cycle after a
  // pop, and tx_data holds the popped byte until the next load.
  always_ff @(posedge txclk or posedge reset) begin
    if (reset) begin
      ld_tx_data <= 1'b0;
      tx_data    <= 8'h00;
      tx_enable  <= 1'b0;
    end else begin
      ld_tx_data <= pop;
      tx_enable  <= drain_en;
      if (pop) begin
        tx_data <= mem[rd_ptr];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge txclk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. After a load, the FSM waits for the uart to go busy and
  // then idle again, even if drain_en drops in the meantime.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (pop)       state_next = LOAD;
      LOAD:                     state_next = WAIT_BUSY;
      WAIT_BUSY: if (!tx_empty) state_next = WAIT_DONE;
      WAIT_DONE: if (tx_empty)  state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

`ifdef UART_TX_FEEDER_OVF_EN
  logic drop;
  assign drop = wr_en && full && !pop;

  // Sticky overflow flag. When a new drop and a clear happen on the same edge,
  // the new drop takes priority.
  always_ff @(posedge txclk or posedge reset) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Testbench for uart_tx_feeder: directed vectors plus a simple uart model.
// The model holds tx_empty low for 10 cycles after each sampled load.
module tb_uart_tx_feeder;

`ifdef UART_TX_FEEDER_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic       txclk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       drain_en;
  logic       full;
  logic       fifo_empty;
  logic [3:0] count;
  logic       ovf;
  logic       ovf_clr;
  logic       ld_tx_data;
  logic [7:0] tx_data;
  logic       tx_enable;
  logic       tx_empty;

  int checks = 0;
  int errors = 0;

  // uart model state
  int         busy_cnt = 0;
  bit         uart_auto = 1'b1;
  logic       ld_pre;
  logic       prev_ld = 1'b0;
  logic [7:0] d_pre;
  logic [7:0] loads[$];

  typedef struct {
    logic       wr_en;
    logic [7:0] wr_data;
    logic       ovf_clr;
    logic [3:0] exp_count;
    logic       exp_full;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[13];

  uart_tx_feeder #(.DEPTH(8), .ADDR_W(3)) dut (
    .txclk      (txclk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .drain_en   (drain_en),
    .full       (full),
    .fifo_empty (fifo_empty),
    .count      (count),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr),
    .ld_tx_data (ld_tx_data),
    .tx_data    (tx_data),
    .tx_enable  (tx_enable),
    .tx_empty   (tx_empty)
  );

  always #5 txclk = ~txclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock cycle. Samples the load strobe at the negedge, then advances the
  // uart model just after the rising edge.
  task automatic tick();
    @(negedge txclk);
    ld_pre = ld_tx_data;
    d_pre  = tx_data;
    @(posedge txclk);
    #1;
    if (ld_pre === 1'b1) begin
      chk("ld_single", {31'd0, prev_ld}, 32'd0);
      chk("ld_while_busy", busy_cnt, 32'd0);
      loads.push_back(d_pre);
      $display("load byte %02h at %0t", d_pre, $time);
      if (uart_auto) begin
        tx_empty = 1'b0;
        busy_cnt = 10;
      end
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) tx_empty = 1'b1;
    end
    prev_ld = ld_pre;
  endtask

  task automatic do_reset();
    wr_en = 1'b0; wr_data = 8'h00; drain_en = 1'b0; ovf_clr = 1'b0;
    reset = 1'b1;
    busy_cnt = 0; tx_empty = 1'b1;
    tick(); tick();
    reset = 1'b0;
    loads.delete();
  endtask

  task automatic wait_loads(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (loads.size() >= n) break;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Fill the table for the fill/overflow test (drain disabled).
    for (int i = 0; i < 10; i++) begin
      vecs[i].wr_en     = 1'b1;
      vecs[i].wr_data   = 8'(i + 1);
      vecs[i].ovf_clr   = 1'b0;
      vecs[i].exp_count = (i + 1 > 8) ? 4'd8 : 4'(i + 1);
      vecs[i].exp_full  = (i >= 7);
      vecs[i].exp_ovf   = OVF_ON && (i >= 8);
    end
    vecs[10] = '{wr_en: 1'b0, wr_data: 8'h00, ovf_clr: 1'b1, exp_count: 4'd8, exp_full: 1'b1, exp_ovf: 1'b0};
    vecs[11] = '{wr_en: 1'b1, wr_data: 8'hEE, ovf_clr: 1'b1, exp_count: 4'd8, exp_full: 1'b1, exp_ovf: OVF_ON};
    vecs[12] = '{wr_en: 1'b0, wr_data: 8'h00, ovf_clr: 1'b1, exp_count: 4'd8, exp_full: 1'b1, exp_ovf: 1'b0};

    tx_empty = 1'b1;
    do_reset();
    chk("rst_count", count, 0);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ld", ld_tx_data, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_ovf", ovf, 0);
    chk("rst_tx_enable", tx_enable, 0);

    // Test 1: async reset while WAIT_DONE with 3 bytes queued, then release while uart busy.
    drain_en = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'hAA; tick();
    wr_data = 8'hBB; tick();
    wr_data = 8'hCC; tick();
    wr_data = 8'hDD; tick();
    wr_en = 1'b0;
    tick(); tick();
    chk("t1_count_pre", count, 3);
    #2;
    reset = 1'b1;
    #1;
    chk("t1_count", count, 0);
    chk("t1_empty", fifo_empty, 1);
    chk("t1_ld", ld_tx_data, 0);
    chk("t1_tx_data", tx_data, 8'h00);
    chk("t1_ovf", ovf, 0);
    tick();
    reset = 1'b0;
    loads.delete();
    wr_en = 1'b1; wr_data = 8'h44; tick();
    wr_en = 1'b0; tick();
    chk("t1_busy_hold_count", count, 1);
    chk("t1_busy_hold_ld", ld_tx_data, 0);
    wait_loads(1, 40);
    chk("t1_loads", loads.size(), 1);
    if (loads.size() >= 1) chk("t1_byte", loads[0], 8'h44);

    // Test 2: single-byte latency.
    do_reset();
    drain_en = 1'b1; tick();
    chk("t2_tx_enable", tx_enable, 1);
    wr_en = 1'b1; wr_data = 8'h07; tick();
    chk("t2_count_n", count, 1);
    chk("t2_ld_n", ld_tx_data, 0);
    wr_en = 1'b0; tick();
    chk("t2_ld_n1", ld_tx_data, 1);
    chk("t2_data", tx_data, 8'h07);
    chk("t2_count_n1", count, 0);
    tick();
    chk("t2_ld_n2", ld_tx_data, 0);
    chk("t2_data_hold", tx_data, 8'h07);

    // Test 3: three bytes paced by a busy uart.
    do_reset();
    drain_en = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'hAA; tick();
    wr_data = 8'h55; tick();
    wr_data = 8'h0F; tick();
    wr_en = 1'b0;
    wait_loads(3, 120);
    chk("t3_loads", loads.size(), 3);
    if (loads.size() >= 3) begin
      chk("t3_b0", loads[0], 8'hAA);
      chk("t3_b1", loads[1], 8'h55);
      chk("t3_b2", loads[2], 8'h0F);
    end

    // Test 4: fill past DEPTH with drain disabled, overflow flag behaviour.
    do_reset();
    for (int i = 0; i < 13; i++) begin
      wr_en = vecs[i].wr_en;
      wr_data = vecs[i].wr_data;
      ovf_clr = vecs[i].ovf_clr;
      tick();
      chk($sformatf("t4_count[%0d]", i), count, vecs[i].exp_count);
      chk($sformatf("t4_full[%0d]", i), full, vecs[i].exp_full);
      chk($sformatf("t4_ovf[%0d]", i), ovf, vecs[i].exp_ovf);
      chk($sformatf("t4_ld[%0d]", i), ld_tx_data, 0);
    end
    wr_en = 1'b0; ovf_clr = 1'b0;

    // Test 5: push coincident with pop on a full FIFO, then drain across the wrap.
    loads.delete();
    drain_en = 1'b1; wr_en = 1'b1; wr_data = 8'h09; tick();
    wr_en = 1'b0;
    chk("t5_ld", ld_tx_data, 1);
    chk("t5_first", tx_data, 8'h01);
    chk("t5_count", count, 8);
    chk("t5_full", full, 1);
    chk("t5_ovf", ovf, 0);
    wait_loads(9, 300);
    chk("t5_loads", loads.size(), 9);
    for (int i = 0; i < 9; i++) begin
      if (i < loads.size()) chk($sformatf("t5_b%0d", i), loads[i], 32'(i + 1));
    end
    chk("t5_drained", fifo_empty, 1);

    // Test 6: drain_en dropped during WAIT_BUSY, then reasserted.
    do_reset();
    drain_en = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'h31; tick();
    wr_data = 8'h32; tick();
    wr_en = 1'b0; tick();
    drain_en = 1'b0;
    repeat (20) tick();
    chk("t6_loads", loads.size(), 1);
    if (loads.size() >= 1) chk("t6_b0", loads[0], 8'h31);
    chk("t6_count", count, 1);
    chk("t6_ld_parked", ld_tx_data, 0);
    chk("t6_tx_enable", tx_enable, 0);
    drain_en = 1'b1; tick();
    chk("t6_resume_ld", ld_tx_data, 1);
    chk("t6_resume_data", tx_data, 8'h32);
    chk("t6_resume_count", count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
